// File: rtl/dice_roller_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dice_roller_multi_pkg
//  Brief    : Shared FSM encodings, LFSR taps and helpers for the dice roller.
//  Revision : 1.0
// ============================================================================
package dice_roller_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROLL   = 2'd1,
        ST_SETTLE = 2'd2
    } dice_state_t;

    localparam logic [7:0] C_LFSR_TAPS = 8'hB8;
    localparam int         C_FACE_W    = 4;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? C_LFSR_TAPS : 8'h00);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    function automatic logic [7:0] lfsr_seed(input logic [7:0] base, input int idx);
        logic [7:0] s;
        s = base ^ 8'(8'h35 * (idx + 1));
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dice_roller_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : dice_channel
//  Brief    : One die: free-running LFSR, roll/settle FSM and settle counter.
//  Revision : 1.0
// ============================================================================
module dice_channel
    import dice_roller_multi_pkg::*;
#(
    parameter int         FACES        = 6,
    parameter int         SETTLE_TICKS = 5,
    parameter logic [7:0] SEED         = 8'hA5,
    parameter int         CH_IDX       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start,
    output logic [C_FACE_W-1:0] dice,
    output logic                valid,
    output logic                done
);

    localparam logic [7:0] c_seed      = lfsr_seed(SEED, CH_IDX);
    localparam logic [3:0] c_settle_ld = 4'(SETTLE_TICKS - 1);

    logic [7:0]          r_lfsr;
    dice_state_t         r_state, w_state_nxt;
    logic [3:0]          r_settle_cnt, w_settle_nxt;
    logic [C_FACE_W-1:0] r_dice, w_dice_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_done, w_done_nxt;
    logic [C_FACE_W-1:0] w_draw;

    assign w_draw = C_FACE_W'(r_lfsr % 8'(FACES)) + C_FACE_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        w_dice_nxt   = r_dice;
        w_valid_nxt  = r_valid;
        w_done_nxt   = 1'b0;
        if (tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_dice_nxt  = w_draw;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_ROLL;
                    end
                end
                ST_ROLL: begin
                    w_dice_nxt = w_draw;
                    if (!start) begin
                        w_settle_nxt = c_settle_ld;
                        w_state_nxt  = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (start) begin
                        w_dice_nxt  = w_draw;
                        w_state_nxt = ST_ROLL;
                    end else if (r_settle_cnt == 4'd0) begin
                        // Freeze tick: the face shown is the last settle draw.
                        w_valid_nxt = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_dice_nxt   = w_draw;
                        w_settle_nxt = r_settle_cnt - 4'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr       <= c_seed;
            r_state      <= ST_IDLE;
            r_settle_cnt <= 4'd0;
            r_dice       <= C_FACE_W'(1);
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_lfsr       <= lfsr_step(r_lfsr);
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_dice       <= w_dice_nxt;
            r_valid      <= w_valid_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign dice  = r_dice;
    assign valid = r_valid;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: rtl/dice_roller_multi.sv
`default_nettype none
// ============================================================================
//  Module   : dice_roller_multi
//  Brief    : N-channel electronic dice with shared roll-tick divider.
//             Define DICE_SUM_EN to add the registered 8-bit `sum` output.
//  Revision : 1.0
// ============================================================================
module dice_roller_multi
    import dice_roller_multi_pkg::*;
#(
    parameter int         N_DICE       = 2,
    parameter int         FACES        = 6,
    parameter int         TICK_DIV     = 100,
    parameter int         SETTLE_TICKS = 5,
    parameter logic [7:0] SEED         = 8'hA5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_DICE-1:0]            start,
    output logic [C_FACE_W*N_DICE-1:0]   dice,
    output logic [N_DICE-1:0]            valid,
    output logic [N_DICE-1:0]            done,
`ifdef DICE_SUM_EN
    output logic [7:0]                   sum,
`endif
    output logic                         tick
);

    localparam int                c_div_w    = $clog2(TICK_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(TICK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_pre  = c_div_w'(TICK_DIV - 2);

    logic [c_div_w-1:0] r_div_cnt;
    logic               r_tick;

    // Tick is registered one count early so it is high exactly while the
    // counter sits at its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= (r_div_cnt == c_div_last) ? '0 : r_div_cnt + c_div_w'(1);
            r_tick    <= (r_div_cnt == c_div_pre);
        end
    end

    assign tick = r_tick;

    for (genvar gi = 0; gi < N_DICE; gi++) begin : g_ch
        dice_channel #(
            .FACES        (FACES),
            .SETTLE_TICKS (SETTLE_TICKS),
            .SEED         (SEED),
            .CH_IDX       (gi)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (r_tick),
            .start (start[gi]),
            .dice  (dice[C_FACE_W*gi +: C_FACE_W]),
            .valid (valid[gi]),
            .done  (done[gi])
        );
    end

`ifdef DICE_SUM_EN
    if (N_DICE * FACES > 255) begin : g_sum_range_err
        $error("dice_roller_multi: N_DICE*FACES exceeds the 8-bit sum range");
    end

    logic [7:0] w_sum;
    logic [7:0] r_sum;

    always_comb begin
        w_sum = 8'd0;
        for (int i = 0; i < N_DICE; i++) begin
            w_sum = w_sum + 8'(dice[C_FACE_W*i +: C_FACE_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= 8'(N_DICE);
        end else begin
            r_sum <= w_sum;
        end
    end

    assign sum = r_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dice_roller_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dice_roller_multi
//  Brief    : Directed self-checking bench for dice_roller_multi (2 dice, d6).
//  Revision : 1.0
// ============================================================================
module tb_dice_roller_multi;

    localparam logic [7:0] SEED0 = 8'h90;  // A5 ^ 35
    localparam logic [7:0] SEED1 = 8'hCF;  // A5 ^ 6A

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start = 2'b00;
    logic [7:0] dice;
    logic [1:0] valid;
    logic [1:0] done;
    logic       tick;
`ifdef DICE_SUM_EN
    logic [7:0] sum;
`endif

    always #5 clk = ~clk;

    dice_roller_multi #(
        .N_DICE       (2),
        .FACES        (6),
        .TICK_DIV     (4),
        .SETTLE_TICKS (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dice  (dice),
        .valid (valid),
        .done  (done),
`ifdef DICE_SUM_EN
        .sum   (sum),
`endif
        .tick  (tick)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [3:0] draw(input logic [7:0] v);
        return 4'(v % 8'd6) + 4'd1;
    endfunction

    // Reference LFSRs and tick phase, advanced on the same edges as the DUT.
    logic [7:0] m_lfsr0, m_lfsr1;
    int         m_div;

    always @(posedge clk) begin
        if (rst) begin
            m_lfsr0 <= SEED0;
            m_lfsr1 <= SEED1;
            m_div   <= 0;
        end else begin
            m_lfsr0 <= lfsr_next(m_lfsr0);
            m_lfsr1 <= lfsr_next(m_lfsr1);
            m_div   <= (m_div == 3) ? 0 : m_div + 1;
        end
    end

    int         done_cnt0 = 0;
    int         done_cnt1 = 0;
    int         dbl_cnt   = 0;
    logic [1:0] prev_done = 2'b00;

    always @(negedge clk) begin
        prev_done <= done;
        if (done[0]) done_cnt0 <= done_cnt0 + 1;
        if (done[1]) done_cnt1 <= done_cnt1 + 1;
        if ((done & prev_done) != 2'b00) dbl_cnt <= dbl_cnt + 1;
    end

    logic [3:0] exp_d0 = 4'd1;
    logic [3:0] exp_d1 = 4'd1;
    logic [1:0] exp_valid = 2'b00;

    task automatic goto_tick();
        @(negedge clk);
        while (m_div != 3) @(negedge clk);
    endtask

    // Apply start, wait for the tick, predict draws, check the cycle after.
    task automatic do_tick(input string tag, input logic [1:0] st,
                           input logic [1:0] drw, input logic [1:0] exp_done);
        start = st;
        goto_tick();
        check({tag, "_tick"}, 32'(tick), 32'd1);
        if (drw[0]) exp_d0 = draw(m_lfsr0);
        if (drw[1]) exp_d1 = draw(m_lfsr1);
        @(negedge clk);
        check({tag, "_dice"},  32'(dice),  32'({exp_d1, exp_d0}));
        check({tag, "_valid"}, 32'(valid), 32'(exp_valid));
        check({tag, "_done"},  32'(done),  32'(exp_done));
    endtask

    int bins0 [8];
    int bins1 [8];
    int bad_range;
    int model_mism;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int f = 0; f < 8; f++) begin
            bins0[f] = 0;
            bins1[f] = 0;
        end
        bad_range  = 0;
        model_mism = 0;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_dice",  32'(dice),  32'h11);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_tick",  32'(tick),  32'h0);
`ifdef DICE_SUM_EN
        check("rst_sum",   32'(sum),   32'd2);
`endif
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("tick_after_rst", 32'(tick), 32'(k == 3));
        end
        @(negedge clk);

        // Single roll on channel 0
        repeat (5) do_tick("roll", 2'b01, 2'b01, 2'b00);
        repeat (3) do_tick("settle", 2'b00, 2'b01, 2'b00);
        exp_valid = 2'b01;
        do_tick("freeze", 2'b00, 2'b00, 2'b01);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'h0);
        check("done_cnt0_a", 32'(done_cnt0), 32'd1);
        check("done_cnt1_a", 32'(done_cnt1), 32'd0);

        // Re-press during settle
        exp_valid[0] = 1'b0;
        do_tick("re_start", 2'b01, 2'b01, 2'b00);
        do_tick("re_roll0", 2'b01, 2'b01, 2'b00);
        do_tick("re_rel",   2'b00, 2'b01, 2'b00);
        do_tick("re_press", 2'b01, 2'b01, 2'b00);
        do_tick("re_roll1", 2'b01, 2'b01, 2'b00);
        repeat (3) do_tick("re_settle", 2'b00, 2'b01, 2'b00);
        exp_valid[0] = 1'b1;
        do_tick("re_freeze", 2'b00, 2'b00, 2'b01);
        @(negedge clk);
        check("done_cnt0_b", 32'(done_cnt0), 32'd2);

        // Sub-tick start pulse between ticks is ignored
        start = 2'b10;
        @(negedge clk);
        start = 2'b00;
        do_tick("short_pulse", 2'b00, 2'b00, 2'b00);

        // Range sweep, both channels rolling together
        exp_valid = 2'b00;
        do_tick("sweep_start", 2'b11, 2'b11, 2'b00);
        for (int n = 0; n < 10000; n++) begin
            goto_tick();
            exp_d0 = draw(m_lfsr0);
            exp_d1 = draw(m_lfsr1);
            @(negedge clk);
            if (dice !== {exp_d1, exp_d0}) model_mism++;
            if (dice[3:0] >= 4'd1 && dice[3:0] <= 4'd6) bins0[dice[3:0]]++;
            else bad_range++;
            if (dice[7:4] >= 4'd1 && dice[7:4] <= 4'd6) bins1[dice[7:4]]++;
            else bad_range++;
        end
        check("sweep_model_mism", 32'(model_mism), 32'd0);
        check("sweep_out_of_range", 32'(bad_range), 32'd0);
        for (int f = 1; f <= 6; f++) begin
            check($sformatf("sweep_ch0_face%0d_in_band", f),
                  32'(bins0[f] >= 1417 && bins0[f] <= 1916), 32'd1);
            check($sformatf("sweep_ch1_face%0d_in_band", f),
                  32'(bins1[f] >= 1417 && bins1[f] <= 1916), 32'd1);
        end
        repeat (3) do_tick("both_settle", 2'b00, 2'b11, 2'b00);
        exp_valid = 2'b11;
        do_tick("both_freeze", 2'b00, 2'b00, 2'b11);
`ifdef DICE_SUM_EN
        check("sum_both", 32'(sum), 32'({4'b0, exp_d0} + {4'b0, exp_d1}));
`endif
        @(negedge clk);
        check("done_cnt0_c", 32'(done_cnt0), 32'd3);
        check("done_cnt1_c", 32'(done_cnt1), 32'd1);

        // Reset during settle on channel 1
        exp_valid[1] = 1'b0;
        do_tick("rs_start", 2'b10, 2'b10, 2'b00);
        do_tick("rs_roll",  2'b10, 2'b10, 2'b00);
        do_tick("rs_rel",   2'b00, 2'b10, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        check("rs_dice",  32'(dice),  32'h11);
        check("rs_valid", 32'(valid), 32'h0);
        check("rs_done",  32'(done),  32'h0);
`ifdef DICE_SUM_EN
        check("rs_sum",   32'(sum),   32'd2);
`endif
        @(negedge clk);
        rst       = 1'b0;
        exp_d0    = 4'd1;
        exp_d1    = 4'd1;
        exp_valid = 2'b00;
        repeat (5) do_tick("post_rst", 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        check("done_cnt0_final", 32'(done_cnt0), 32'd3);
        check("done_cnt1_final", 32'(done_cnt1), 32'd1);
        check("done_back_to_back", 32'(dbl_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
